// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle FSM (master) and the datapath (slave).
interface multicycle_control_if;
  logic [5:0] Op;
  logic       MemReady;
  logic [1:0] ALUOP;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       IorD;
  logic       IRWrite;
  logic       PCWrite;
  logic       Branch;
  logic       MemWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic [1:0] PCSrc;
  logic       IllegalOp;
  logic [3:0] State;

  modport master (
    input  Op, MemReady,
    output ALUOP, ALUSrcA, ALUSrcB, IorD, IRWrite, PCWrite, Branch,
           MemWrite, RegWrite, RegDst, MemtoReg, PCSrc, IllegalOp, State
  );

  modport slave (
    output Op, MemReady,
    input  ALUOP, ALUSrcA, ALUSrcB, IorD, IRWrite, PCWrite, Branch,
           MemWrite, RegWrite, RegDst, MemtoReg, PCSrc, IllegalOp, State
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: one state per cycle, 3-5 cycles per instruction.
// FETCH, MEMRD and MEMWR hold until MemReady; reset masks all write enables combinationally.
module multicycle_control (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_control_if.master ctl
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic [3:0] w_out_state;

  logic [1:0] w_aluop;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic       w_iord;
  logic       w_irwrite;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_memwrite;
  logic       w_regwrite;
  logic       w_regdst;
  logic       w_memtoreg;
  logic [1:0] w_pcsrc;
  logic       w_illegal;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:  w_next_state = ctl.MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (ctl.Op)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_R:         w_next_state = S_EXEC;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_ADDI:      w_next_state = S_ADDIEX;
          OP_J:         w_next_state = S_JUMP;
          default:      w_next_state = S_FETCH;
        endcase
      end
      // An opcode that changed away from lw/sw here is dropped back to FETCH.
      S_MEMADR: begin
        if (ctl.Op == OP_LW)      w_next_state = S_MEMRD;
        else if (ctl.Op == OP_SW) w_next_state = S_MEMWR;
        else                      w_next_state = S_FETCH;
      end
      S_MEMRD:  w_next_state = ctl.MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next_state = ctl.MemReady ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next_state = S_ALUWB;
      S_ADDIEX: w_next_state = S_ADDIWB;
      default:  w_next_state = S_FETCH;
    endcase
  end

  // While in reset the outputs decode as FETCH, with write strobes gated off.
  assign w_out_state = rst_n ? r_state : S_FETCH;

  always_comb begin
    w_aluop    = 2'b00;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_iord     = 1'b0;
    w_irwrite  = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_pcsrc    = 2'b00;
    w_illegal  = 1'b0;
    case (w_out_state)
      S_FETCH: begin
        w_alusrcb = 2'b01;
        w_irwrite = ctl.MemReady & rst_n;
        w_pcwrite = ctl.MemReady & rst_n;
      end
      S_DECODE: begin
        w_alusrcb = 2'b11;
        w_illegal = !(ctl.Op inside {OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J});
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_MEMRD:  w_iord = 1'b1;
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXEC: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b01;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
      end
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign ctl.ALUOP     = w_aluop;
  assign ctl.ALUSrcA   = w_alusrca;
  assign ctl.ALUSrcB   = w_alusrcb;
  assign ctl.IorD      = w_iord;
  assign ctl.IRWrite   = w_irwrite;
  assign ctl.PCWrite   = w_pcwrite;
  assign ctl.Branch    = w_branch;
  assign ctl.MemWrite  = w_memwrite;
  assign ctl.RegWrite  = w_regwrite;
  assign ctl.RegDst    = w_regdst;
  assign ctl.MemtoReg  = w_memtoreg;
  assign ctl.PCSrc     = w_pcsrc;
  assign ctl.IllegalOp = w_illegal;
  assign ctl.State     = r_state;

endmodule
